// File: rtl/apb_addr_dec_v2_pkg.sv
// apb_addr_dec_v2_pkg: shared decoder defaults, vmicro16 slave index map and decode-width helper
package apb_addr_dec_v2_pkg;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_MSB = 7;
  localparam int DEF_LSB = 4;
  localparam int DEF_ERR_CNT_W = 8;
  typedef enum logic [DEF_MSB-DEF_LSB:0] {
    SLV_BRAM, SLV_GPIO0, SLV_UART0, SLV_TIMR0, SLV_GPIO1, SLV_REGS, SLV_GPIO2, SLV_WDOG
  } slave_e;
  function automatic int mask_range(input int msb, input int lsb);
    return 2 ** (msb - lsb + 1);
  endfunction
endpackage

// File: rtl/apb_addr_dec_v2_if.sv
// apb_addr_dec_v2_if: master address/handshake in, slave selects, latched index and error count out
interface apb_addr_dec_v2_if
  import apb_addr_dec_v2_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MSB = DEF_MSB,
  parameter int LSB = DEF_LSB,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
);
  localparam int MASK_RANGE = mask_range(MSB, LSB);
  logic [ADDR_WIDTH-1:0] addr;
  logic psel_in;
  logic penable_in;
  logic err_clr;
  logic [MASK_RANGE-1:0] pselx;
  logic [MSB-LSB:0] sel_idx;
  logic [MSB-LSB:0] sel_q;
  logic dec_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  modport master (output addr, psel_in, penable_in, err_clr, input pselx, sel_idx, sel_q, dec_err, err_cnt);
  modport slave (input addr, psel_in, penable_in, err_clr, output pselx, sel_idx, sel_q, dec_err, err_cnt);
endinterface

// File: rtl/apb_addr_dec_v2_sat_cnt.sv
// apb_addr_dec_v2_sat_cnt: saturating counter, clear beats increment; ports clk, reset (async low), clr, inc, cnt
module apb_addr_dec_v2_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/apb_addr_dec_v2.sv
// apb_addr_dec_v2: one-hot APB slave select from addr[MSB:LSB] plus setup-latched index and, with APB_ADDR_DEC_ERR_CNT_EN, a saturating decode-error count; ports clk, reset (async low), bus (slave modport)
module apb_addr_dec_v2
  import apb_addr_dec_v2_pkg::*;
#(
  parameter int MSB = DEF_MSB,
  parameter int LSB = DEF_LSB,
  parameter int N_SLAVES = mask_range(MSB, LSB)
) (
  input  logic                  clk,
  input  logic                  reset,
  apb_addr_dec_v2_if.slave      bus
);
  localparam int SW = MSB - LSB + 1;
  localparam int MASK_RANGE = mask_range(MSB, LSB);
  logic [SW-1:0] field;
  logic [MASK_RANGE-1:0] psel;
  logic [SW-1:0] sel_q, sel_d;
  logic setup;
  assign field = bus.addr[MSB:LSB];
  for (genvar p = 0; p < MASK_RANGE; p++) begin : g_dec
    if (p < N_SLAVES) begin : g_pop
      assign psel[p] = field == SW'(p);
    end else begin : g_unpop
      assign psel[p] = 1'b0;
    end
  end
  assign bus.pselx = psel;
  assign bus.sel_idx = field;
  assign bus.dec_err = {1'b0, field} >= (SW + 1)'(N_SLAVES);
  assign setup = bus.psel_in & ~bus.penable_in;
  always_comb sel_d = setup ? field : sel_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sel_q <= '0;
    else sel_q <= sel_d;
  assign bus.sel_q = sel_q;
`ifdef APB_ADDR_DEC_ERR_CNT_EN
  apb_addr_dec_v2_sat_cnt #(.W($bits(bus.err_cnt))) u_err_cnt (
    .clk(clk),
    .reset(reset),
    .clr(bus.err_clr),
    .inc(setup & bus.dec_err),
    .cnt(bus.err_cnt)
  );
`else
  assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_apb_addr_dec_v2.sv
// tb_apb_addr_dec_v2: directed checks of decode, setup latching, error counting and async reset
module tb_apb_addr_dec_v2;
`ifdef APB_ADDR_DEC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk;
  logic rst0_n, rst1_n;
  int n_tests = 0;
  int n_fail = 0;
  apb_addr_dec_v2_if b0 ();
  apb_addr_dec_v2_if #(.ERR_CNT_W(2)) b1 ();
  apb_addr_dec_v2 u0 (.clk(clk), .reset(rst0_n), .bus(b0.slave));
  apb_addr_dec_v2 #(.N_SLAVES(12)) u1 (.clk(clk), .reset(rst1_n), .bus(b1.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer1(input logic [15:0] a);
    b1.addr = a; b1.psel_in = 1'b1; b1.penable_in = 1'b0;
    cyc();
    b1.penable_in = 1'b1;
    cyc();
    b1.psel_in = 1'b0; b1.penable_in = 1'b0;
  endtask
  function automatic logic [31:0] ec(input int v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    b0.addr = '0; b0.psel_in = 1'b0; b0.penable_in = 1'b0; b0.err_clr = 1'b0;
    b1.addr = '0; b1.psel_in = 1'b0; b1.penable_in = 1'b0; b1.err_clr = 1'b0;
    cyc(); cyc();
    chk("rst_sel_q0", 32'(b0.sel_q), 0);
    chk("rst_err_cnt0", 32'(b0.err_cnt), 0);
    chk("rst_sel_q1", 32'(b1.sel_q), 0);
    chk("rst_err_cnt1", 32'(b1.err_cnt), 0);
    b0.addr = 16'h0035; #1;
    chk("psel_35", 32'(b0.pselx), 32'h0008);
    chk("idx_35", 32'(b0.sel_idx), 3);
    chk("err_35", 32'(b0.dec_err), 0);
    b0.addr = 16'hFF35; #1;
    chk("psel_ff35", 32'(b0.pselx), 32'h0008);
    b0.addr = 16'h00F0; #1;
    chk("psel_f0", 32'(b0.pselx), 32'h8000);
    chk("err_f0", 32'(b0.dec_err), 0);
    b0.addr = 16'h0000; #1;
    chk("psel_00", 32'(b0.pselx), 32'h0001);
    rst0_n = 1'b1; rst1_n = 1'b1;
    cyc();
    b0.addr = 16'h0050; b0.psel_in = 1'b1;
    cyc();
    chk("selq_setup5", 32'(b0.sel_q), 5);
    b0.penable_in = 1'b1; b0.addr = 16'h0090;
    cyc();
    chk("selq_access", 32'(b0.sel_q), 5);
    b0.psel_in = 1'b0; b0.penable_in = 1'b0;
    cyc();
    chk("selq_idle", 32'(b0.sel_q), 5);
    b0.psel_in = 1'b1;
    cyc();
    chk("selq_setup9", 32'(b0.sel_q), 9);
    chk("err_cnt0_none", 32'(b0.err_cnt), 0);
    b0.psel_in = 1'b0;
    b1.addr = 16'h00C0; #1;
    chk("psel_c0_n12", 32'(b1.pselx), 0);
    chk("err_c0_n12", 32'(b1.dec_err), 1);
    b1.addr = 16'h00B0; #1;
    chk("psel_b0_n12", 32'(b1.pselx), 32'h0800);
    chk("err_b0_n12", 32'(b1.dec_err), 0);
    xfer1(16'h00C0);
    cyc();
    chk("cnt_one_xfer", 32'(b1.err_cnt), ec(1));
    chk("selq_c", 32'(b1.sel_q), 12);
    xfer1(16'h00D0);
    chk("cnt_two", 32'(b1.err_cnt), ec(2));
    xfer1(16'h00E0);
    xfer1(16'h00F0);
    xfer1(16'h00C0);
    chk("cnt_sat", 32'(b1.err_cnt), ec(3));
    b1.addr = 16'h00C0; b1.psel_in = 1'b1; b1.err_clr = 1'b1;
    cyc();
    chk("cnt_clr_prio", 32'(b1.err_cnt), 0);
    b1.err_clr = 1'b0; b1.penable_in = 1'b1;
    cyc();
    b1.psel_in = 1'b0; b1.penable_in = 1'b0;
    xfer1(16'h00C0);
    xfer1(16'h00D0);
    b1.addr = 16'h0050; b1.psel_in = 1'b1;
    cyc();
    b1.penable_in = 1'b1;
    cyc();
    chk("pre_rst_selq", 32'(b1.sel_q), 5);
    chk("pre_rst_cnt", 32'(b1.err_cnt), ec(2));
    #2 rst1_n = 1'b0; b1.addr = 16'h0030;
    #1;
    chk("async_selq", 32'(b1.sel_q), 0);
    chk("async_cnt", 32'(b1.err_cnt), 0);
    chk("rst_psel", 32'(b1.pselx), 32'h0008);
    cyc();
    chk("hold_selq", 32'(b1.sel_q), 0);
    b1.psel_in = 1'b0; b1.penable_in = 1'b0;
    rst1_n = 1'b1;
    cyc();
    b1.addr = 16'h0070; b1.psel_in = 1'b1;
    cyc();
    chk("reload_selq", 32'(b1.sel_q), 7);
    b1.psel_in = 1'b0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
